// File: rtl/store_pkg.sv
// ============================================================================
// Module      : store_pkg
// Description : Store-type encodings, FSM state type and size decode shared
//               by the store read-modify-write unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package store_pkg;

    localparam logic [1:0] ST_WORD  = 2'b00;
    localparam logic [1:0] ST_BYTE  = 2'b01;
    localparam logic [1:0] ST_HALF  = 2'b10;
    localparam logic [1:0] ST_DWORD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_WR0  = 3'd2,
`ifdef STORE_MISALIGNED_EN
        S_RD1  = 3'd4,
        S_WR1  = 3'd5,
`endif
        S_RESP = 3'd3
    } storeState_t;

    function automatic logic [3:0] storeSize(input logic [1:0] storeType);
        case (storeType)
            ST_BYTE: return 4'd1;
            ST_HALF: return 4'd2;
            ST_WORD: return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_merge.sv
// ============================================================================
// Module      : store_lane_merge
// Description : Combinational byte-lane merge of store data into a read word,
//               selecting either the low or the spill-over (high) portion.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_lane_merge #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              i_rdWord,
    input  logic [XLEN-1:0]              i_wrData,
    input  logic [$clog2(XLEN/8)-1:0]    i_off,
    input  logic [3:0]                   i_size,
    input  logic                         i_partHigh,
    output logic [XLEN-1:0]              o_merged
);

    localparam int NBYTES = XLEN / 8;

    logic [2*NBYTES-1:0] w_sizeOnes;
    logic [2*NBYTES-1:0] w_mask;
    logic [2*XLEN-1:0]   w_shifted;
    logic [NBYTES-1:0]   w_laneMask;
    logic [XLEN-1:0]     w_laneData;

    always_comb begin
        w_sizeOnes = '0;
        for (int i = 0; i < 2*NBYTES; i++) begin
            w_sizeOnes[i] = (i < int'(i_size));
        end
    end

    // Shifting across a double-width window puts the spill-over bytes of a
    // misaligned store into the upper half, already aligned to lane 0.
    assign w_mask     = w_sizeOnes << i_off;
    assign w_shifted  = {{XLEN{1'b0}}, i_wrData} << {i_off, 3'b000};
    assign w_laneMask = i_partHigh ? w_mask[2*NBYTES-1:NBYTES] : w_mask[NBYTES-1:0];
    assign w_laneData = i_partHigh ? w_shifted[2*XLEN-1:XLEN] : w_shifted[XLEN-1:0];

    generate
        for (genvar g = 0; g < NBYTES; g++) begin : g_lane
            assign o_merged[8*g +: 8] = w_laneMask[g] ? w_laneData[8*g +: 8]
                                                      : i_rdWord[8*g +: 8];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/store_rmw_unit.sv
// ============================================================================
// Module      : store_rmw_unit
// Description : Sequential read-modify-write store unit with a req/ack memory
//               port. Define STORE_MISALIGNED_EN to split misaligned stores
//               across two words instead of rejecting them.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_rmw_unit
    import store_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] Addr,
    input  logic [XLEN-1:0] rd2,
    input  logic [1:0]      StoreType,
    output logic            st_done,
    output logic            st_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    storeState_t      r_state, w_nextState;
    logic [XLEN-1:0]  r_data, r_memAddr, r_memWdata;
    logic [XLEN-1:0]  w_nextAddr, w_nextWdata, w_merged, w_alignedAddr;
    logic [OFFW-1:0]  r_off, w_inOff;
    logic [3:0]       r_size, w_inSize;
    logic             r_err;
    logic             w_accept, w_illegal, w_misaligned, w_fullWord, w_reject, w_partHigh;

    assign w_accept      = st_valid && (r_state == S_IDLE);
    assign w_inOff       = Addr[OFFW-1:0];
    assign w_inSize      = storeSize(StoreType);
    assign w_alignedAddr = {Addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign w_illegal     = (XLEN == 32) && (StoreType == ST_DWORD);
    assign w_misaligned  = (5'(w_inOff) + 5'(w_inSize)) > 5'(NBYTES);
    assign w_fullWord    = (w_inSize == 4'(NBYTES)) && (w_inOff == '0);

`ifdef STORE_MISALIGNED_EN
    logic            r_split;
    logic [XLEN-1:0] r_wordAddr;

    assign w_reject   = w_illegal;
    assign w_partHigh = (r_state == S_RD1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_split    <= 1'b0;
            r_wordAddr <= '0;
        end else if (w_accept) begin
            r_split    <= w_misaligned;
            r_wordAddr <= w_alignedAddr;
        end
    end
`else
    assign w_reject   = w_illegal || w_misaligned;
    assign w_partHigh = 1'b0;
`endif

    store_lane_merge #(.XLEN(XLEN)) u_merge (
        .i_rdWord   (mem_rdata),
        .i_wrData   (r_data),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_partHigh (w_partHigh),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_data     <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_memAddr  <= w_nextAddr;
            r_memWdata <= w_nextWdata;
            if (w_accept) begin
                r_data <= rd2;
                r_off  <= w_inOff;
                r_size <= w_inSize;
                r_err  <= w_reject;
            end
        end
    end

    // The write word is formed while the read is acknowledged, so the read
    // data never needs its own holding register.
    always_comb begin
        w_nextState = r_state;
        w_nextAddr  = r_memAddr;
        w_nextWdata = r_memWdata;
        case (r_state)
            S_IDLE: begin
                if (st_valid) begin
                    w_nextAddr = w_alignedAddr;
                    if (w_reject) begin
                        w_nextState = S_RESP;
                    end else if (w_fullWord) begin
                        w_nextState = S_WR0;
                        w_nextWdata = rd2;
                    end else begin
                        w_nextState = S_RD0;
                    end
                end
            end
            S_RD0: begin
                if (mem_ack) begin
                    w_nextState = S_WR0;
                    w_nextWdata = w_merged;
                end
            end
            S_WR0: begin
                if (mem_ack) begin
`ifdef STORE_MISALIGNED_EN
                    if (r_split) begin
                        w_nextState = S_RD1;
                        w_nextAddr  = r_wordAddr + XLEN'(NBYTES);
                    end else begin
                        w_nextState = S_RESP;
                    end
`else
                    w_nextState = S_RESP;
`endif
                end
            end
`ifdef STORE_MISALIGNED_EN
            S_RD1: begin
                if (mem_ack) begin
                    w_nextState = S_WR1;
                    w_nextWdata = w_merged;
                end
            end
            S_WR1: begin
                if (mem_ack) begin
                    w_nextState = S_RESP;
                end
            end
`endif
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    assign st_ready  = (r_state == S_IDLE);
    assign st_done   = (r_state == S_RESP) && !r_err;
    assign st_err    = (r_state == S_RESP) && r_err;
`ifdef STORE_MISALIGNED_EN
    assign mem_req   = (r_state == S_RD0) || (r_state == S_WR0) ||
                       (r_state == S_RD1) || (r_state == S_WR1);
    assign mem_we    = (r_state == S_WR0) || (r_state == S_WR1);
`else
    assign mem_req   = (r_state == S_RD0) || (r_state == S_WR0);
    assign mem_we    = (r_state == S_WR0);
`endif
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

endmodule

`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
// ============================================================================
// Module      : tb_store_rmw_unit
// Description : Scoreboard bench for store_rmw_unit (XLEN=32) with a
//               variable-latency memory responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_rmw_unit;
    import store_pkg::*;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;
    localparam logic [31:0] INIT_WORD = 32'ha5b4c3d2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] Addr = '0;
    logic [31:0] rd2 = '0;
    logic [1:0]  StoreType = '0;
    logic        st_done, st_err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    store_rmw_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .Addr(Addr), .rd2(rd2), .StoreType(StoreType), .st_done(st_done),
        .st_err(st_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t expQ[$];

    task automatic pushExp(input int kind, input logic [31:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
        expQ.push_back(e);
    endtask

    // Memory model: acks after ackDelay wait cycles, commits writes afterwards.
    logic [31:0] mem [16];
    int          ackDelay = 0;
    int          rCnt = 0;
    logic        pendW = 1'b0;
    logic [3:0]  pendIdx = '0;
    logic [31:0] pendData = '0;

    always @(posedge clk) begin
        #1;
        if (mem_ack) begin
            if (pendW && !reset) mem[pendIdx] = pendData;
            mem_ack = 1'b0;
            rCnt = 0;
        end
        if (!mem_req || reset) begin
            rCnt = 0;
        end else if (rCnt >= ackDelay) begin
            mem_ack  = 1'b1;
            pendW    = mem_we;
            pendIdx  = mem_addr[5:2];
            pendData = mem_wdata;
            if (!mem_we) mem_rdata = mem[mem_addr[5:2]];
        end else begin
            rCnt++;
        end
    end

    // Monitor: compares every memory cycle and completion against the queue front.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (mem_req) begin
                if (expQ.size() == 0) begin
                    check("mem_req_unexpected", {31'b0, mem_req}, 32'd0);
                end else begin
                    e = expQ[0];
                    check("mem_op_expected", {31'b0, (e.kind == K_RD) || (e.kind == K_WR)}, 32'd1);
                    check("mem_we", {31'b0, mem_we}, {31'b0, e.kind == K_WR});
                    check("mem_addr", mem_addr, e.addr);
                    if (e.kind == K_WR) check("mem_wdata", mem_wdata, e.data);
                    if (mem_ack) void'(expQ.pop_front());
                end
            end
            if (st_done || st_err) begin
                if (expQ.size() == 0) begin
                    check("resp_unexpected", {30'b0, st_done, st_err}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("resp_kind", {30'b0, st_done, st_err},
                          (e.kind == K_DONE) ? 32'd2 : 32'd1);
                    check("resp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic resetMem();
        for (int i = 0; i < 16; i++) mem[i] = INIT_WORD;
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                           input int dly, output int acc);
        int w;
        ackDelay = dly;
        @(negedge clk);
        w = 0;
        while (!st_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("st_ready_wait", {31'b0, st_ready}, 32'd1);
        st_valid = 1'b1; Addr = a; rd2 = d; StoreType = t;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        Addr = $urandom; rd2 = $urandom; StoreType = 2'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (expQ.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("drain_timeout", expQ.size(), 32'd0);
        expQ.delete();
        @(posedge clk);
    endtask

    initial begin
        int a;
        int w;
        resetMem();
        #1;
        check("rst_st_ready", {31'b0, st_ready}, 32'd1);
        check("rst_st_done", {31'b0, st_done}, 32'd0);
        check("rst_st_err", {31'b0, st_err}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Byte store, lane 1.
        doStore(32'h1, 32'hffffffff, ST_BYTE, 0, a);
        pushExp(K_RD, 0, 0, 0); pushExp(K_WR, 0, 32'ha5b4ffd2, 0); pushExp(K_DONE, 0, 0, a + 2);
        drain();

        // Halfword store, lanes 2-3, slow memory.
        resetMem();
        doStore(32'h2, 32'hffffffff, ST_HALF, 4, a);
        pushExp(K_RD, 0, 0, 0); pushExp(K_WR, 0, 32'hffffc3d2, 0); pushExp(K_DONE, 0, 0, a + 10);
        drain();

        // Full-width aligned word: no read.
        resetMem();
        doStore(32'h0, 32'h12345678, ST_WORD, 0, a);
        pushExp(K_WR, 0, 32'h12345678, 0); pushExp(K_DONE, 0, 0, a + 1);
        drain();

        // Misaligned word at offset 3.
        resetMem();
        doStore(32'h3, 32'h11223344, ST_WORD, 0, a);
`ifdef STORE_MISALIGNED_EN
        pushExp(K_RD, 0, 0, 0); pushExp(K_WR, 0, 32'h44b4c3d2, 0);
        pushExp(K_RD, 4, 0, 0); pushExp(K_WR, 4, 32'ha5112233, 0);
        pushExp(K_DONE, 0, 0, a + 4);
`else
        pushExp(K_ERR, 0, 0, a);
`endif
        drain();

        // Doubleword on a 32-bit unit is illegal.
        doStore(32'h8, 32'hdeadbeef, ST_DWORD, 0, a);
        pushExp(K_ERR, 0, 0, a);
        drain();

        // Byte store into the top lane of word 1.
        resetMem();
        doStore(32'h7, 32'h000000aa, ST_BYTE, 0, a);
        pushExp(K_RD, 4, 0, 0); pushExp(K_WR, 4, 32'haab4c3d2, 0); pushExp(K_DONE, 0, 0, a + 2);
        drain();

        // Misaligned halfword at offset 3, slow memory.
        resetMem();
        doStore(32'h3, 32'h0000beef, ST_HALF, 2, a);
`ifdef STORE_MISALIGNED_EN
        pushExp(K_RD, 0, 0, 0); pushExp(K_WR, 0, 32'hefb4c3d2, 0);
        pushExp(K_RD, 4, 0, 0); pushExp(K_WR, 4, 32'ha5b4c3be, 0);
        pushExp(K_DONE, 0, 0, a + 12);
`else
        pushExp(K_ERR, 0, 0, a);
`endif
        drain();

        // Reset while the write is outstanding abandons the store.
        resetMem();
        doStore(32'h1, 32'hffffffff, ST_BYTE, 3, a);
        pushExp(K_RD, 0, 0, 0); pushExp(K_WR, 0, 32'ha5b4ffd2, 0);
        w = 0;
        @(negedge clk);
        while (!(mem_req && mem_we) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("reach_wr0", {31'b0, mem_req && mem_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_mem_req_drop", {31'b0, mem_req}, 32'd0);
        check("async_st_ready", {31'b0, st_ready}, 32'd1);
        check("async_mem_addr", mem_addr, 32'd0);
        expQ.delete();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abandoned_write", mem[0], INIT_WORD);
        check("ready_after_reset", {31'b0, st_ready}, 32'd1);

        doStore(32'h0, 32'h0000005a, ST_BYTE, 1, a);
        pushExp(K_RD, 0, 0, 0); pushExp(K_WR, 0, 32'ha5b4c35a, 0); pushExp(K_DONE, 0, 0, a + 4);
        drain();
        check("final_mem0", mem[0], 32'ha5b4c35a);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
